trig_pulse_gen: RTL and testbench
=================================

# trig_pulse_gen

Parametrised multi-channel pulse and indicator generator; the successor to the single-output power-on trigger/LED block. It provides one power-on trigger output plus CHANNELS independent outputs. Each output can be configured as a one-shot pulse, a periodic blink, or steady-on, with lengths given in prescaled time units. It sits at the top level next to the global reset logic and drives front-panel LEDs and downstream trigger inputs.

## Interface
- CHANNELS, 4: number of independent pulse channels (≥1)
- PRESCALE, 400: CLK cycles per time unit (≥1)
- CNT_W, 16: width of unit counters and length fields
- POR_DLY, 40000: units PorTrig stays high after reset release before its low pulse
- POR_LEN, 4: CLK cycles PorTrig is held low (≥1)
- CLK  input  1  system clock; all logic on rising edge
- RstBtn  input  1  reset, synchronous, active-high
- Start  input  CHANNELS  per-channel start strobe, one cycle
- Stop  input  CHANNELS  per-channel abort strobe, one cycle
- Mode  input  2*CHANNELS  per channel: 00 off, 01 one-shot, 10 periodic, 11 steady
- HighLen  input  CNT_W*CHANNELS  high time in units, unsigned
- Period  input  CNT_W*CHANNELS  period in units, unsigned (periodic mode only)
- Out  output  CHANNELS  channel outputs, registered
- Busy  output  CHANNELS  channel not IDLE
- Done  output  CHANNELS  one-cycle one-shot completion strobe
- PorTrig  output  1  power-on trigger, active-low pulse, registered

## Operation
- One clock domain. Reset is synchronous and active-high. The clock port is CLK and the reset port is RstBtn.
- Reset values: Out=0, Busy=0, Done=0, PorTrig=1, all channel FSMs IDLE, all counters 0. Reset mid-operation aborts everything. The cycle after RstBtn deasserts behaves as a fresh power-up.
- Power-on FSM states: POR_WAIT → POR_PULSE → POR_DONE.
  - POR_WAIT: PorTrig=1. Counts POR_DLY*PRESCALE cycles, then moves to POR_PULSE.
  - POR_PULSE: PorTrig=0 for exactly POR_LEN cycles.
  - POR_DONE: PorTrig=1 permanently until the next reset. There is no retrigger.
- Each channel has its own prescale counter (0..PRESCALE-1, width clog2(PRESCALE), minimum 1 bit) and unit counter (CNT_W). Timing is therefore exact per channel and not phase-shared.
- Mode, HighLen and Period are latched on an accepted Start. Changing them while Busy has no effect.
- Channel FSM states: IDLE, HIGH, LOW.
  - IDLE + Start, Mode=00: ignored.
  - IDLE + Start, Mode=01/10: go to HIGH with counters cleared. If latched HighLen=0, see the edge cases below.
  - IDLE + Start, Mode=11: go to HIGH and stay there until Stop.
  - HIGH: Out=1. After HighLen*PRESCALE cycles:
    - one-shot → IDLE, with Done=1 for one cycle;
    - periodic → LOW, if Period>HighLen;
    - periodic with Period≤HighLen → stay HIGH (continuous) until Stop.
  - LOW: Out=0. After (Period−HighLen)*PRESCALE cycles → HIGH. Repeats until Stop.
- Stop in any non-IDLE state → IDLE. Out=0 and Busy=0 next cycle, no Done.
- Start while Busy:
  - one-shot: retrigger; counters clear and HIGH restarts the full HighLen duration.
  - periodic/steady: ignored.
- Start and Stop in the same cycle: Stop wins; the channel ends in IDLE.
- One-shot with HighLen=0: Out never rises. The FSM passes through HIGH for 1 cycle with Out forced 0; Busy=1 for that cycle; Done fires the following cycle.
- Periodic with HighLen=0: Out stays 0; the channel stays Busy until Stop.
- Unit counter arithmetic is unsigned CNT_W bits. The compare is a terminal compare (==), never wraps. The maximum HighLen of 2^CNT_W−1 must work.
- Channels are fully independent. Simultaneous events on different channels do not interact.

## Timing
- Start sampled at edge t → Busy=1 and Out=1 from t+1.
- One-shot: Out high cycles t+1 .. t+HighLen*PRESCALE. At t+HighLen*PRESCALE+1: Out=0, Busy=0, Done=1 (one cycle).
- Periodic: high HighLen*PRESCALE cycles, low (Period−HighLen)*PRESCALE cycles, with no gap cycles between phases.
- Stop at t → Out=0, Busy=0 at t+1.
- PorTrig: reset released at edge r. PorTrig=1 through r+POR_DLY*PRESCALE. PorTrig=0 for the next POR_LEN cycles, then 1.
- All outputs are registered; no combinational input→output path.

## Test plan
- PRESCALE=4, POR_DLY=3, POR_LEN=4, release reset → PorTrig high 12 cycles, low 4 cycles, then high for 200+ cycles.
- Ch0 one-shot, HighLen=3, Start at t → Out0 high t+1..t+12; Out0=0, Busy0=0, Done0=1 at t+13; Done0 low at t+14.
- Ch1 periodic, HighLen=2, Period=5 → Out1 pattern: 8 high, 12 low, repeated 3 times. Stop during a low phase → Busy1=0 next cycle, Done1 never asserted.
- Ch0 one-shot HighLen=3, retrigger Start at 6th high cycle → Out0 stays high 12 cycles after the retrigger, single Done0.
- Edge cases:
  - HighLen=0 one-shot → Out0 never 1, Done0 at t+2.
  - Periodic HighLen=2, Period=2 → Out continuously high.
  - Start+Stop same cycle in IDLE → no change.
  - Mode=00 Start → ignored.
- Assert RstBtn mid-pulse on all channels and during POR_PULSE → next cycle: all Out/Busy/Done=0, PorTrig=1. The POR sequence restarts from zero after release.

Source files
------------

// File: rtl/trig_pulse_gen.sv
// Multi-channel one-shot / periodic / steady pulse generator
// with a single power-on trigger that pulses low once after reset.
module trig_pulse_gen #(
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 400,
  parameter int CNT_W    = 16,
  parameter int POR_DLY  = 40000,
  parameter int POR_LEN  = 4
) (
  input  logic                      CLK,
  input  logic                      RstBtn,
  input  logic [CHANNELS-1:0]       Start,
  input  logic [CHANNELS-1:0]       Stop,
  input  logic [2*CHANNELS-1:0]     Mode,
  input  logic [CNT_W*CHANNELS-1:0] HighLen,
  input  logic [CNT_W*CHANNELS-1:0] Period,
  output logic [CHANNELS-1:0]       Out,
  output logic [CHANNELS-1:0]       Busy,
  output logic [CHANNELS-1:0]       Done,
  output logic                      PorTrig
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam int POR_CYC = POR_DLY * PRESCALE;
  localparam int POR_MAX = (POR_CYC > POR_LEN) ? POR_CYC : POR_LEN;
  localparam int PCW = (POR_MAX > 1) ? $clog2(POR_MAX) : 1;
  localparam logic [PCW-1:0] WAIT_LAST =
    PCW'((POR_CYC > 0) ? POR_CYC - 1 : 0);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(POR_LEN - 1);

  localparam logic [1:0] POR_WAIT  = 2'd0;
  localparam logic [1:0] POR_PULSE = 2'd1;
  localparam logic [1:0] POR_DONE  = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  localparam logic [1:0] M_OFF    = 2'd0;
  localparam logic [1:0] M_ONE    = 2'd1;
  localparam logic [1:0] M_PER    = 2'd2;
  localparam logic [1:0] M_STEADY = 2'd3;

  logic [1:0]     por_st;
  logic [PCW-1:0] por_cnt;

  always_ff @(posedge CLK) begin
    if (RstBtn) begin
      por_st  <= POR_WAIT;
      por_cnt <= '0;
      PorTrig <= 1'b1;
    end else begin
      case (por_st)
        POR_WAIT: begin
          if (por_cnt == WAIT_LAST) begin
            por_st  <= POR_PULSE;
            por_cnt <= '0;
            PorTrig <= 1'b0;
          end else begin
            por_cnt <= por_cnt + PCW'(1);
          end
        end
        POR_PULSE: begin
          if (por_cnt == PULSE_LAST) begin
            por_st  <= POR_DONE;
            por_cnt <= '0;
            PorTrig <= 1'b1;
          end else begin
            por_cnt <= por_cnt + PCW'(1);
          end
        end
        POR_DONE: PorTrig <= 1'b1;
        default: begin
          por_st  <= POR_WAIT;
          por_cnt <= '0;
          PorTrig <= 1'b1;
        end
      endcase
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]       st;
    logic [1:0]       md;
    logic [CNT_W-1:0] hl;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] uc;
    logic [PW-1:0]    pc;
    logic             out_q;
    logic             busy_q;
    logic             done_q;
    logic [1:0]       mode_in;
    logic [CNT_W-1:0] hl_in;
    logic [CNT_W-1:0] per_in;
    logic             ps_wrap;
    logic             hi_last;
    logic             lo_last;
    logic             hold_high;

    assign mode_in = Mode[2*i +: 2];
    assign hl_in   = HighLen[CNT_W*i +: CNT_W];
    assign per_in  = Period[CNT_W*i +: CNT_W];

    // Terminal compares: phase ends on the last prescale tick of its last unit
    assign ps_wrap   = (pc == PS_LAST);
    assign hi_last   = ps_wrap && (uc == hl - CNT_W'(1));
    assign lo_last   = ps_wrap && (uc == per - hl - CNT_W'(1));
    assign hold_high = (md == M_STEADY) ||
                       ((md == M_PER) && (hl == '0));

    always_ff @(posedge CLK) begin
      if (RstBtn) begin
        st     <= S_IDLE;
        md     <= M_OFF;
        hl     <= '0;
        per    <= '0;
        uc     <= '0;
        pc     <= '0;
        out_q  <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (Stop[i]) begin
          st     <= S_IDLE;
          out_q  <= 1'b0;
          busy_q <= 1'b0;
          uc     <= '0;
          pc     <= '0;
        end else if (Start[i] && !busy_q && mode_in != M_OFF) begin
          st     <= S_HIGH;
          md     <= mode_in;
          hl     <= hl_in;
          per    <= per_in;
          busy_q <= 1'b1;
          out_q  <= (mode_in == M_STEADY) || (hl_in != '0);
          uc     <= '0;
          pc     <= '0;
        end else if (Start[i] && busy_q && md == M_ONE) begin
          st    <= S_HIGH;
          out_q <= (hl != '0);
          uc    <= '0;
          pc    <= '0;
        end else begin
          case (st)
            S_IDLE: ;
            S_HIGH: begin
              if (hold_high) begin
                uc <= '0;
                pc <= '0;
              end else if (hl == '0 || hi_last) begin
                uc <= '0;
                pc <= '0;
                if (md == M_ONE) begin
                  st     <= S_IDLE;
                  out_q  <= 1'b0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                end else if (per > hl) begin
                  st    <= S_LOW;
                  out_q <= 1'b0;
                end
              end else if (ps_wrap) begin
                pc <= '0;
                uc <= uc + CNT_W'(1);
              end else begin
                pc <= pc + PW'(1);
              end
            end
            S_LOW: begin
              if (lo_last) begin
                st    <= S_HIGH;
                out_q <= 1'b1;
                uc    <= '0;
                pc    <= '0;
              end else if (ps_wrap) begin
                pc <= '0;
                uc <= uc + CNT_W'(1);
              end else begin
                pc <= pc + PW'(1);
              end
            end
            default: begin
              st     <= S_IDLE;
              out_q  <= 1'b0;
              busy_q <= 1'b0;
            end
          endcase
        end
      end
    end

    assign Out[i]  = out_q;
    assign Busy[i] = busy_q;
    assign Done[i] = done_q;
  end

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Bench for trig_pulse_gen: cycle-level reference model plus
// directed scenarios with hand-computed counts.
module tb_trig_pulse_gen;

  localparam int CH = 2;
  localparam int PS = 4;
  localparam int CW = 8;
  localparam int PD = 3;
  localparam int PL = 4;
  localparam int D  = PD * PS;

  logic             CLK = 1'b0;
  logic             RstBtn;
  logic [CH-1:0]    Start;
  logic [CH-1:0]    Stop;
  logic [2*CH-1:0]  Mode;
  logic [CW*CH-1:0] HighLen;
  logic [CW*CH-1:0] Period;
  logic [CH-1:0]    Out;
  logic [CH-1:0]    Busy;
  logic [CH-1:0]    Done;
  logic             PorTrig;

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  trig_pulse_gen #(
    .CHANNELS(CH),
    .PRESCALE(PS),
    .CNT_W(CW),
    .POR_DLY(PD),
    .POR_LEN(PL)
  ) dut (
    .CLK(CLK),
    .RstBtn(RstBtn),
    .Start(Start),
    .Stop(Stop),
    .Mode(Mode),
    .HighLen(HighLen),
    .Period(Period),
    .Out(Out),
    .Busy(Busy),
    .Done(Done),
    .PorTrig(PorTrig)
  );

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: per channel, "active" flag and elapsed cycles since start
  bit         mact [CH];
  bit         mdone[CH];
  int         mk   [CH];
  int         mhl  [CH];
  int         mper [CH];
  logic [1:0] mmode[CH];
  int         pj = -1;

  function automatic logic exp_out(input int c);
    if (!mact[c]) return 1'b0;
    case (mmode[c])
      2'd1: return mhl[c] != 0;
      2'd2: begin
        if (mhl[c] == 0) return 1'b0;
        if (mper[c] <= mhl[c]) return 1'b1;
        return ((mk[c] - 1) % (mper[c] * PS)) < (mhl[c] * PS);
      end
      2'd3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    for (int c = 0; c < CH; c++) begin
      mact[c] = 0; mdone[c] = 0; mk[c] = 0;
      mhl[c] = 0; mper[c] = 0; mmode[c] = 2'd0;
    end
    forever begin
      @(posedge CLK);
      if (RstBtn) pj = -1;
      else if (pj < 1000000) pj++;
      for (int c = 0; c < CH; c++) begin
        mdone[c] = 0;
        if (RstBtn || Stop[c]) begin
          mact[c] = 0;
        end else if (Start[c] && !mact[c] && Mode[2*c +: 2] != 2'd0) begin
          mact[c]  = 1;
          mmode[c] = Mode[2*c +: 2];
          mhl[c]   = int'(HighLen[CW*c +: CW]);
          mper[c]  = int'(Period[CW*c +: CW]);
          mk[c]    = 1;
        end else if (Start[c] && mact[c] && mmode[c] == 2'd1) begin
          mk[c] = 1;
        end else if (mact[c]) begin
          mk[c]++;
          if (mmode[c] == 2'd1 &&
              mk[c] > ((mhl[c] == 0) ? 1 : mhl[c] * PS)) begin
            mact[c]  = 0;
            mdone[c] = 1;
          end
        end
      end
      #1;
      chk("por", PorTrig, (pj >= D - 1 && pj <= D + PL - 2) ? 0 : 1);
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("out%0d", c), Out[c], exp_out(c));
        chk($sformatf("busy%0d", c), Busy[c], mact[c]);
        chk($sformatf("done%0d", c), Done[c], mdone[c]);
      end
    end
  end

  task automatic cfg(input int c, input logic [1:0] m,
                     input int hl, input int pr);
    Mode[2*c +: 2]     = m;
    HighLen[CW*c +: CW] = CW'(hl);
    Period[CW*c +: CW]  = CW'(pr);
  endtask

  task automatic strobe(input logic [CH-1:0] st, input logic [CH-1:0] sp);
    @(negedge CLK);
    Start = st;
    Stop  = sp;
    @(negedge CLK);
    Start = '0;
    Stop  = '0;
  endtask

  task automatic observe(input int c, input int n,
                         output int hi, output int dn, output int df);
    hi = 0; dn = 0; df = -1;
    for (int i = 0; i < n; i++) begin
      if (Out[c]) hi++;
      if (Done[c]) begin
        dn++;
        if (df < 0) df = i;
      end
      @(negedge CLK);
    end
  endtask

  task automatic por_release_check();
    int lo, first;
    lo = 0; first = -1;
    RstBtn = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge CLK);
      if (!PorTrig) begin
        lo++;
        if (first < 0) first = j;
      end
    end
    chk("por_first_low", first, 11);
    chk("por_low_cycles", lo, 4);
  endtask

  int hi, dn, df;
  bit found;

  initial begin
    RstBtn = 1'b1; Start = '0; Stop = '0;
    Mode = '0; HighLen = '0; Period = '0;
    repeat (3) @(negedge CLK);
    por_release_check();

    cfg(0, 2'd1, 3, 0);
    strobe(2'b01, 2'b00);
    observe(0, 16, hi, dn, df);
    chk("os_high", hi, 12);
    chk("os_done_at", df, 12);
    chk("os_done_cnt", dn, 1);

    cfg(1, 2'd2, 2, 5);
    strobe(2'b10, 2'b00);
    observe(1, 60, hi, dn, df);
    chk("per_high", hi, 24);
    chk("per_done", dn, 0);
    observe(1, 10, hi, dn, df);
    chk("per_high2", hi, 8);
    strobe(2'b00, 2'b10);
    chk("per_stop_busy", Busy[1], 0);
    chk("per_stop_out", Out[1], 0);

    cfg(0, 2'd1, 3, 0);
    strobe(2'b01, 2'b00);
    observe(0, 4, hi, dn, df);
    chk("rt_pre_high", hi, 4);
    strobe(2'b01, 2'b00);
    observe(0, 16, hi, dn, df);
    chk("rt_high", hi, 12);
    chk("rt_done_at", df, 12);
    chk("rt_done_cnt", dn, 1);

    cfg(0, 2'd1, 0, 0);
    strobe(2'b01, 2'b00);
    chk("hl0_busy", Busy[0], 1);
    observe(0, 5, hi, dn, df);
    chk("hl0_high", hi, 0);
    chk("hl0_done_at", df, 1);
    chk("hl0_done_cnt", dn, 1);

    cfg(1, 2'd2, 2, 2);
    strobe(2'b10, 2'b00);
    observe(1, 40, hi, dn, df);
    chk("cont_high", hi, 40);
    strobe(2'b00, 2'b10);

    cfg(0, 2'd1, 3, 0);
    strobe(2'b01, 2'b01);
    chk("ss_busy", Busy[0], 0);
    observe(0, 4, hi, dn, df);
    chk("ss_high", hi, 0);

    cfg(1, 2'd0, 3, 5);
    strobe(2'b10, 2'b00);
    chk("off_busy", Busy[1], 0);

    cfg(1, 2'd3, 0, 0);
    strobe(2'b10, 2'b00);
    chk("steady_out", Out[1], 1);
    cfg(0, 2'd1, 255, 0);
    strobe(2'b01, 2'b00);
    cfg(0, 2'd2, 1, 9);
    observe(0, 1025, hi, dn, df);
    chk("max_high", hi, 1020);
    chk("max_done_at", df, 1020);
    chk("max_done_cnt", dn, 1);
    chk("steady_hold", Out[1], 1);
    strobe(2'b00, 2'b10);

    RstBtn = 1'b1;
    repeat (2) @(negedge CLK);
    RstBtn = 1'b0;
    cfg(0, 2'd1, 5, 0);
    cfg(1, 2'd2, 2, 5);
    strobe(2'b11, 2'b00);
    found = 0;
    for (int k = 0; k < 60; k++) begin
      if (!PorTrig) begin
        found = 1;
        break;
      end
      @(negedge CLK);
    end
    chk("por_pulse_seen", found, 1);
    chk("mid_busy", Busy, 3);
    RstBtn = 1'b1;
    @(negedge CLK);
    chk("rst_out", Out, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_por", PorTrig, 1);
    por_release_check();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
